alu_rr_arbiter: RTL and testbench

Shares one instance of the team's `alu` module (combinational, WIDTH-parameterised, 3-bit op select) between two independent requesters. Each requester has a valid/ready request channel and a valid/ready response channel. Arbitration is round-robin. Operands, op and result are registered, so the shared ALU sits between two register stages. Sits between client engines and the single ALU datapath.

---
 rtl/alu_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Round-robin share of one combinational ALU between two valid/ready requesters.
// Operands and result are registered around the ALU; one transaction in flight.

module alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = '0;
    case (sel)
      3'b000:  out = in0 + in1;
      3'b001:  out = in0 - in1;
      3'b010:  out = in0 >> 1;
      3'b011:  out = in0 << 1;
      3'b100:  out = in0 & in1;
      3'b101:  out = in0 | in1;
      3'b110:  out = in0 ^ in1;
      default: out = ~in0;
    endcase
  end

endmodule

module alu_rr_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_in0,
  input  logic [WIDTH-1:0] req0_in1,
  input  logic [2:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_in0,
  input  logic [WIDTH-1:0] req1_in1,
  input  logic [2:0]       req1_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_out,
  output logic [2:0]       rsp0_flags,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_out,
  output logic [2:0]       rsp1_flags,
  output logic             busy,
  output logic             grant_id
);

  localparam int unsigned FLAG_W = 3;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_n;
  logic               last_grant, last_grant_n;
  logic               grant_id_n;
  logic               win0, win1;
  logic               cap_ops, cap_res, rsp_done;
  logic [WIDTH-1:0]   op_a, op_b, op_a_n, op_b_n;
  logic [2:0]         op_sel, op_sel_n;
  logic [WIDTH-1:0]   alu_out;
  logic [WIDTH-1:0]   res_out;
  logic [FLAG_W-1:0]  res_flags, alu_flags;

  alu #(.WIDTH(WIDTH)) u_alu (
    .in0 (op_a),
    .in1 (op_b),
    .sel (op_sel),
    .out (alu_out)
  );

  // {neg, pos, zero} under signed interpretation
  assign alu_flags = {alu_out[WIDTH-1], !alu_out[WIDTH-1] && (|alu_out), ~(|alu_out)};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      grant_id   <= grant_id_n;
    end
  end

  // Arbitration, handshakes and sequencing; readies are suppressed during reset
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    grant_id_n   = grant_id;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    cap_ops      = 1'b0;
    cap_res      = 1'b0;
    rsp_done     = 1'b0;
    win1         = req1_valid && (!req0_valid || !last_grant);
    win0         = req0_valid && !win1;
    op_a_n       = win1 ? req1_in0 : req0_in0;
    op_b_n       = win1 ? req1_in1 : req0_in1;
    op_sel_n     = win1 ? req1_sel : req0_sel;
    case (state)
      IDLE: begin
        req0_ready = win0 && !rst;
        req1_ready = win1 && !rst;
        if (win0 || win1) begin
          cap_ops    = 1'b1;
          grant_id_n = win1;
          state_n    = EXEC;
        end
      end
      EXEC: begin
        cap_res = 1'b1;
        state_n = RESP;
      end
      RESP: begin
        if (grant_id ? rsp1_ready : rsp0_ready) begin
          rsp_done     = 1'b1;
          last_grant_n = grant_id;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= '0;
      res_out    <= '0;
      res_flags  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      if (cap_ops) begin
        op_a   <= op_a_n;
        op_b   <= op_b_n;
        op_sel <= op_sel_n;
      end
      if (cap_res) begin
        res_out    <= alu_out;
        res_flags  <= alu_flags;
        rsp0_valid <= !grant_id;
        rsp1_valid <= grant_id;
      end else if (rsp_done) begin
        rsp0_valid <= 1'b0;
        rsp1_valid <= 1'b0;
      end
    end
  end

  // Single result register feeds both channels; only the owner's valid is raised
  assign rsp0_out   = res_out;
  assign rsp1_out   = res_out;
  assign rsp0_flags = res_flags;
  assign rsp1_flags = res_flags;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed vector table plus hand sequences and a random stress run for alu_rr_arbiter.

module tb_alu_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_in0, req0_in1, req1_in0, req1_in1;
  logic [2:0]  req0_sel, req1_sel;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_out, rsp1_out;
  logic [2:0]  rsp0_flags, rsp1_flags;
  logic        busy, grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in0(req0_in0),
    .req0_in1(req0_in1), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in0(req1_in0),
    .req1_in1(req1_in1), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(rsp0_out),
    .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(rsp1_out),
    .rsp1_flags(rsp1_flags),
    .busy(busy), .grant_id(grant_id)
  );

  typedef struct {
    logic        rid;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic [2:0]  exp_flags;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_req(input logic rid, input logic v, input logic [2:0] s,
                         input logic [31:0] a, input logic [31:0] b);
    if (rid) begin
      req1_valid = v; req1_sel = s; req1_in0 = a; req1_in1 = b;
    end else begin
      req0_valid = v; req0_sel = s; req0_in0 = a; req0_in1 = b;
    end
  endtask

  function automatic logic [31:0] model_out(input logic [2:0] s, input logic [31:0] a,
                                            input logic [31:0] b);
    case (s)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a >> 1;
      3'd3: return a << 1;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [2:0] model_flags(input logic [31:0] r);
    if (r == 32'd0) return 3'b001;
    if (r[31])      return 3'b100;
    return 3'b010;
  endfunction

  // Single transaction with both response readies high: fixed 3-cycle shape
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    set_req(v.rid, 1'b1, v.sel, v.a, v.b);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    check("vec_ready_own", 32'(v.rid ? req1_ready : req0_ready), 32'd1);
    check("vec_ready_other", 32'(v.rid ? req0_ready : req1_ready), 32'd0);
    @(negedge clk);
    set_req(v.rid, 1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    check("vec_exec_busy", 32'(busy), 32'd1);
    check("vec_grant_id", 32'(grant_id), 32'(v.rid));
    check("vec_exec_novalid", 32'(rsp0_valid | rsp1_valid), 32'd0);
    @(negedge clk); #1;
    check("vec_rsp_valid_own", 32'(v.rid ? rsp1_valid : rsp0_valid), 32'd1);
    check("vec_rsp_valid_other", 32'(v.rid ? rsp0_valid : rsp1_valid), 32'd0);
    check("vec_out", v.rid ? rsp1_out : rsp0_out, v.exp_out);
    check("vec_flags", 32'(v.rid ? rsp1_flags : rsp0_flags), 32'(v.exp_flags));
    check("vec_resp_busy", 32'(busy), 32'd1);
    @(negedge clk); #1;
    check("vec_idle_busy", 32'(busy), 32'd0);
    check("vec_idle_valid", 32'(rsp0_valid | rsp1_valid), 32'd0);
  endtask

  // Stress state
  logic        pend [2];
  logic [2:0]  s_q  [2];
  logic [31:0] a_q  [2];
  logic [31:0] b_q  [2];
  logic        exp_pend;
  logic        exp_id;
  int          exp_wait;
  logic [31:0] exp_out;
  logic [2:0]  exp_flags;

  initial begin
    vecs[0] = '{1'b0, 3'd0, 32'd5,          32'd7,          32'd12,         3'b010};
    vecs[1] = '{1'b1, 3'd1, 32'd3,          32'd5,          32'hFFFF_FFFE,  3'b100};
    vecs[2] = '{1'b0, 3'd2, 32'h8000_0000,  32'h1234_5678,  32'h4000_0000,  3'b010};
    vecs[3] = '{1'b1, 3'd3, 32'h8000_0001,  32'hFFFF_FFFF,  32'h0000_0002,  3'b010};
    vecs[4] = '{1'b0, 3'd4, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  3'b010};
    vecs[5] = '{1'b1, 3'd5, 32'd0,          32'd0,          32'd0,          3'b001};
    vecs[6] = '{1'b0, 3'd6, 32'hA5A5_A5A5,  32'hA5A5_A5A5,  32'd0,          3'b001};
    vecs[7] = '{1'b1, 3'd7, 32'd0,          32'h5555_5555,  32'hFFFF_FFFF,  3'b100};
    vecs[8] = '{1'b0, 3'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          3'b001};
    vecs[9] = '{1'b1, 3'd1, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  3'b010};

    rst = 1'b1;
    set_req(1'b0, 1'b1, 3'd0, 32'd1, 32'd1);
    set_req(1'b1, 1'b1, 3'd0, 32'd1, 32'd1);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset: readies suppressed even with valids high, outputs at reset values
    @(posedge clk); @(negedge clk); #1;
    check("rst_no_ready0", 32'(req0_ready), 32'd0);
    check("rst_no_ready1", 32'(req1_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("rst_out", rsp0_out | rsp1_out, 32'd0);
    check("rst_flags", 32'(rsp0_flags | rsp1_flags), 32'd0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Both requesters held valid: grants alternate starting with 0
    @(negedge clk);
    set_req(1'b0, 1'b1, 3'd6, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    set_req(1'b1, 1'b1, 3'd7, 32'd0, 32'd0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int   guard;
      logic gid;
      guard = 0;
      #1;
      while (!(req0_ready || req1_ready) && guard < 10) begin
        @(negedge clk); #1; guard++;
      end
      check("alt_not_both", 32'(req0_ready & req1_ready), 32'd0);
      check("alt_grant", 32'(req1_ready), 32'(k % 2));
      gid = req1_ready;
      guard = 0;
      @(negedge clk); #1;
      while (!(gid ? rsp1_valid : rsp0_valid) && guard < 10) begin
        @(negedge clk); #1; guard++;
      end
      check("alt_out", gid ? rsp1_out : rsp0_out, gid ? 32'hFFFF_FFFF : 32'd0);
      check("alt_flags", 32'(gid ? rsp1_flags : rsp0_flags), gid ? 32'd4 : 32'd1);
      @(negedge clk);
    end
    set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);

    // Backpressure on rsp0 holds result and blocks requester 1
    @(negedge clk);
    set_req(1'b0, 1'b1, 3'd3, 32'h8000_0001, 32'd0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    #1;
    check("bp_ready0", 32'(req0_ready), 32'd1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b1, 3'd7, 32'h0F0F_0F0F, 32'd0);
    #1;
    check("bp_exec_ready1", 32'(req1_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("bp_hold_valid", 32'(rsp0_valid), 32'd1);
      check("bp_hold_out", rsp0_out, 32'h0000_0002);
      check("bp_hold_flags", 32'(rsp0_flags), 32'd2);
      check("bp_ready1_blocked", 32'(req1_ready), 32'd0);
    end
    @(negedge clk);
    rsp0_ready = 1'b1;
    #1;
    check("bp_release_valid", 32'(rsp0_valid), 32'd1);
    check("bp_release_ready1", 32'(req1_ready), 32'd0);
    @(negedge clk); #1;
    check("bp_rsp0_cleared", 32'(rsp0_valid), 32'd0);
    check("bp_req1_granted", 32'(req1_ready), 32'd1);
    @(negedge clk);
    set_req(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    check("bp_grant_id1", 32'(grant_id), 32'd1);
    @(negedge clk); #1;
    check("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("bp_rsp1_out", rsp1_out, 32'hF0F0_F0F0);
    check("bp_rsp1_flags", 32'(rsp1_flags), 32'd4);
    check("bp_rsp0_quiet", 32'(rsp0_valid), 32'd0);
    @(negedge clk);

    // Reset during EXEC drops the transaction and restores tie-break to requester 0
    set_req(1'b0, 1'b1, 3'd0, 32'd1, 32'd2);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    check("rx_ready0", 32'(req0_ready), 32'd1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    rst = 1'b1;
    #1;
    check("rx_exec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    set_req(1'b0, 1'b1, 3'd0, 32'd10, 32'd20);
    set_req(1'b1, 1'b1, 3'd0, 32'd100, 32'd1);
    #1;
    check("rx_busy_cleared", 32'(busy), 32'd0);
    check("rx_no_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
    check("rx_out_cleared", rsp0_out, 32'd0);
    check("rx_tie_req0", 32'(req0_ready), 32'd1);
    check("rx_tie_not_req1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    check("rx_exec_novalid", 32'(rsp0_valid), 32'd0);
    @(negedge clk); #1;
    check("rx_new_rsp", 32'(rsp0_valid), 32'd1);
    check("rx_new_out", rsp0_out, 32'd30);
    @(negedge clk);

    // Random stress against a one-transaction reference model
    pend[0] = 1'b0; pend[1] = 1'b0;
    exp_pend = 1'b0; exp_id = 1'b0; exp_wait = 0;
    exp_out = '0; exp_flags = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && cyc < 570 && ($urandom % 3) == 0) begin
          pend[n] = 1'b1;
          s_q[n]  = 3'($urandom);
          a_q[n]  = ($urandom % 4 == 0) ? 32'd0 : $urandom;
          b_q[n]  = ($urandom % 4 == 0) ? a_q[n] : $urandom;
        end
        set_req(n[0], pend[n], s_q[n], a_q[n], b_q[n]);
      end
      rsp0_ready = ($urandom % 3) != 0;
      rsp1_ready = ($urandom % 3) != 0;
      #1;
      if (exp_pend && exp_wait > 0) exp_wait--;
      check("st_two_readies", 32'(req0_ready & req1_ready), 32'd0);
      check("st_rsp0_valid", 32'(rsp0_valid), 32'(exp_pend && exp_wait == 0 && !exp_id));
      check("st_rsp1_valid", 32'(rsp1_valid), 32'(exp_pend && exp_wait == 0 && exp_id));
      if (exp_pend)
        check("st_ready_while_busy", 32'(req0_ready | req1_ready), 32'd0);
      if (exp_pend && exp_wait == 0 && (exp_id ? rsp1_ready : rsp0_ready)) begin
        check("st_out", exp_id ? rsp1_out : rsp0_out, exp_out);
        check("st_flags", 32'(exp_id ? rsp1_flags : rsp0_flags), 32'(exp_flags));
        exp_pend = 1'b0;
      end else if (req0_ready || req1_ready) begin
        exp_id    = req1_ready;
        exp_out   = model_out(s_q[exp_id], a_q[exp_id], b_q[exp_id]);
        exp_flags = model_flags(exp_out);
        exp_pend  = 1'b1;
        exp_wait  = 2;
        pend[exp_id] = 1'b0;
      end
    end
    check("st_drained", 32'(exp_pend | pend[0] | pend[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
